// File: rtl/cmlk_3d_frame_ctrl.sv
// Frame-capture sequencer for the 3D packer: start/abort/trigger control, frame counting, overflow flush.
// Optional capture watchdog is built only when CMLK_FRAME_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module cmlk_3d_frame_ctrl #(
   parameter int unsigned INIT_CYCLES = 16,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TO_CYCLES   = 4194304
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             cmd_start,
   input  logic             cmd_abort,
   input  logic [CNT_W-1:0] cfg_frame_num,
   input  logic [1:0]       cfg_frame_type,
   input  logic             trig,
   input  logic             ddr_ready,
   input  logic             frame_store,
   input  logic             fifo_overflow,
   output logic             init_txn,
   output logic             frame_start,
   output logic [1:0]       frame_type,
   output logic             wr2ddr_en,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ARM, S_CAPTURE, S_FLUSH} state_t;

   localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);

   localparam logic [1:0] CODE_OVF = 2'b01;
   localparam logic [1:0] CODE_TO  = 2'b10;

   state_t           state_q, state_d;
   logic [IW-1:0]    tmr_q, tmr_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       type_q, type_d;
   logic [1:0]       code_q, code_d;
   logic             err_q, err_d;
   logic             fs_q, fs_d;
   logic             done_q, done_d;
   logic             init_q, init_d;
   logic             wr_q, wr_d;
   logic             busy_q, busy_d;
   logic             go_flush;
   logic             to_hit;

`ifdef CMLK_FRAME_TIMEOUT_EN
   localparam int unsigned WW = $clog2(TO_CYCLES + 1);
   localparam logic [WW-1:0] TO_LAST = WW'(TO_CYCLES - 1);

   logic [WW-1:0] wd_q, wd_d;

   // Held at zero outside CAPTURE, so every entry into CAPTURE starts a fresh count.
   always_comb begin
      wd_d = '0;
      if (state_q == S_CAPTURE) wd_d = wd_q + 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (areset) wd_q <= '0;
      else        wd_q <= wd_d;
   end

   assign to_hit = (state_q == S_CAPTURE) && (wd_q == TO_LAST);
`else
   assign to_hit = 1'b0;
`endif

   // NOTE: every variable gets its default before the case so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      num_d    = num_q;
      cnt_d    = cnt_q;
      type_d   = type_q;
      code_d   = code_q;
      err_d    = err_q;
      fs_d     = 1'b0;
      done_d   = 1'b0;
      go_flush = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_start) begin
               num_d   = cfg_frame_num;
               type_d  = cfg_frame_type;
               cnt_d   = '0;
               err_d   = 1'b0;
               code_d  = '0;
               tmr_d   = INIT_LOAD;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            if (cmd_abort)           go_flush = 1'b1;
            else if (tmr_q == '0)    state_d  = S_ARM;
            else                     tmr_d    = tmr_q - 1'b1;
         end
         S_ARM: begin
            if (cmd_abort) begin
               go_flush = 1'b1;
            end else if (fifo_overflow) begin
               go_flush = 1'b1;
               err_d    = 1'b1;
               code_d   = CODE_OVF;
            end else if (trig && ddr_ready) begin
               fs_d    = 1'b1;
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (cmd_abort) begin
               go_flush = 1'b1;
            end else if (fifo_overflow) begin
               go_flush = 1'b1;
               err_d    = 1'b1;
               code_d   = CODE_OVF;
            end else if (to_hit) begin
               go_flush = 1'b1;
               err_d    = 1'b1;
               code_d   = CODE_TO;
            end else if (frame_store) begin
               cnt_d = cnt_q + 1'b1;
               // A latched count of zero means run until aborted.
               if ((num_q != '0) && (cnt_d == num_q)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ARM;
               end
            end
         end
         S_FLUSH: begin
            if (tmr_q == '0) state_d = S_IDLE;
            else             tmr_d   = tmr_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (go_flush) begin
         state_d = S_FLUSH;
         tmr_d   = INIT_LOAD;
      end

      init_d = (state_d == S_INIT) || (state_d == S_FLUSH);
      wr_d   = (state_d == S_CAPTURE);
      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         type_q  <= '0;
         code_q  <= '0;
         err_q   <= 1'b0;
         fs_q    <= 1'b0;
         done_q  <= 1'b0;
         init_q  <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
         code_q  <= code_d;
         err_q   <= err_d;
         fs_q    <= fs_d;
         done_q  <= done_d;
         init_q  <= init_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
      end
   end

   assign init_txn    = init_q;
   assign frame_start = fs_q;
   assign frame_type  = type_q;
   assign wr2ddr_en   = wr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = code_q;
   assign frame_cnt   = cnt_q;

endmodule

// File: doc/cmlk_3d_frame_ctrl.md
# cmlk_3d_frame_ctrl

Frame-capture sequencer for the 3D image packing path. It drives the control inputs of the 3D packer wrapper (`init_txn`, `frame_start`, `frame_type_i`, `wr2ddr_en`) from a software start/abort command and a sensor frame trigger, and counts completed frames via `frame_store`. It reacts to `fifo_overflow` by flushing the packer and flagging an error. It sits between the register/command interface and the packer wrapper, on the same `aclk` domain.

## Interface
Parameters:
- `INIT_CYCLES`, 16: length of every `init_txn` flush pulse, in cycles (≥1).
- `CNT_W`, 16: width of the frame counter and `cfg_frame_num`.
- `TO_CYCLES`, 4194304: capture watchdog limit, in cycles; used only with `CMLK_FRAME_TIMEOUT_EN`.

Ports:
- `aclk` in 1: single clock.
- `areset` in 1: reset, synchronous, active-high.
- `cmd_start` in 1: one-cycle start pulse.
- `cmd_abort` in 1: one-cycle abort pulse.
- `cfg_frame_num` in CNT_W: frames to capture; 0 means continuous.
- `cfg_frame_type` in 2: frame type forwarded to the packer.
- `trig` in 1: sensor frame trigger pulse.
- `ddr_ready` in 1: DDR writer is able to accept data.
- `frame_store` in 1: packer frame-complete pulse.
- `fifo_overflow` in 1: packer FIFO overflow.
- `init_txn` out 1: packer flush.
- `frame_start` out 1: one-cycle frame start pulse.
- `frame_type` out 2: latched `cfg_frame_type`.
- `wr2ddr_en` out 1: packer write enable.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the requested frame count is reached.
- `err` out 1: sticky error; cleared by an accepted `cmd_start` or by `areset`.
- `err_code` out 2: 01 = overflow, 10 = timeout; cleared together with `err`.
- `frame_cnt` out CNT_W: frames completed in the current run.

## Operation
- States: IDLE, INIT, ARM, CAPTURE, FLUSH.
- IDLE
  - `cmd_start` latches `cfg_frame_num` and `cfg_frame_type`, clears `frame_cnt`, `err` and `err_code`, then goes to INIT.
  - `cmd_start` in any other state is ignored.
- INIT: `init_txn`=1 for exactly INIT_CYCLES cycles, then go to ARM.
- ARM
  - When `trig` && `ddr_ready`: pulse `frame_start`, go to CAPTURE.
  - A `trig` while `ddr_ready`=0 is dropped, not queued.
- CAPTURE
  - `wr2ddr_en`=1 throughout; `trig` is ignored.
  - On `frame_store`: `frame_cnt`++ (wraps modulo 2^CNT_W).
  - If latched num≠0 and the new count equals num: pulse `done`, go to IDLE. Otherwise go to ARM.
- Overflow: `fifo_overflow` in ARM or CAPTURE sets `err`=1, `err_code`=01, and goes to FLUSH.
- Abort: `cmd_abort` in INIT, ARM or CAPTURE goes to FLUSH with no error flag and no `done`.
- FLUSH: `init_txn`=1 for INIT_CYCLES cycles, `wr2ddr_en`=0, then go to IDLE.
- Priority within one cycle: `cmd_abort` > `fifo_overflow` > timeout > `frame_store`.
  - Overflow coincident with `frame_store`: the frame is not counted.
  - Abort coincident with `frame_store`: the frame is not counted.
- `cmd_abort` and `fifo_overflow` in IDLE or FLUSH are ignored. An abort during INIT restarts nothing: INIT ends and FLUSH begins.
- `areset` at any point forces IDLE on the next edge, whatever the current state.

## Timing
- All outputs are registered.
- Values during and after reset: `init_txn`, `frame_start`, `wr2ddr_en`, `busy`, `done`, `err` = 0; `err_code`, `frame_type`, `frame_cnt` = 0.
- `cmd_start` sampled at edge t: `busy` and `init_txn` are high from t+1. `init_txn` falls at t+1+INIT_CYCLES.
- Trig accepted at edge t: `frame_start` and `wr2ddr_en` are high at t+1. `frame_start` is low at t+2.
- `frame_store` at edge t: `frame_cnt` updates at t+1 and `wr2ddr_en` drops at t+1. Exception: in continuous mode with a trig accepted at t+1, `wr2ddr_en` returns high at t+2.
- `done` is high at t+1 in the same cycle that `busy` falls.
- Overflow or abort at edge t: `wr2ddr_en`=0 and `init_txn`=1 from t+1, for INIT_CYCLES cycles. `busy` falls at t+1+INIT_CYCLES.
- Back-to-back frames: minimum spacing from `frame_store` to the next `frame_start` is 2 cycles.

## Configuration
- `CMLK_FRAME_TIMEOUT_EN` defined:
  - A watchdog counter is cleared on entry to CAPTURE.
  - If it reaches TO_CYCLES with no `frame_store`: `err`=1, `err_code`=10, go to FLUSH.
- Not defined: no watchdog logic is built, CAPTURE waits indefinitely, and `err_code` 10 never occurs.

## Test plan
- Num=3, type=2, `ddr_ready`=1, trig 10 cycles after INIT ends each time, then `frame_store` → three `frame_start` pulses, `frame_type`=2, `frame_cnt` 1,2,3, a single `done`, `busy` low at the end.
- Num=0, 5 frames, then `cmd_abort` in ARM → `frame_cnt`=5, `init_txn` high 16 cycles, no `done`, `err`=0.
- `fifo_overflow` in CAPTURE coincident with `frame_store` → `frame_cnt` unchanged, `err`=1, `err_code`=01, flush of 16 cycles. The next `cmd_start` clears `err`.
- Trig while `ddr_ready`=0 → no `frame_start`. Trig after `ddr_ready`=1 → `frame_start` 1 cycle later.
- With `CMLK_FRAME_TIMEOUT_EN` and TO_CYCLES=100, no `frame_store` → `err_code`=10 after 100 cycles in CAPTURE. Without the macro, still in CAPTURE after 1000 cycles.
- `areset` mid-CAPTURE → next cycle all outputs 0. A `cmd_start` during CAPTURE is ignored.
